uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Two-port arbiter and sequencer that shares one `tx_serial` transmitter between two byte producers, for example the Forth console and a debug/trace source. It accepts bytes over valid/ready handshakes and drives the transmitter's `sbyte`/`send` pair, tracking `busy` to pace transfers. A producer keeps the grant for a whole packet, up to the byte marked `last`. Grants alternate round-robin between packets, and a timeout releases a grant whose owner stalls.

## Interface
- `LOCK_TIMEOUT`, default 100000: clk100 cycles a locked requester may leave `valid` low between bytes before the grant is revoked (1 ms at 100 MHz). Legal range 2..2^20-1.
- `clk100`  in  1  system clock, 100 MHz.
- `reset_n`  in  1  reset, synchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  requester has a byte; must stay high with stable data/last until the matching ready pulse.
- `req0_data`, `req1_data`  in  8  byte to send.
- `req0_last`, `req1_last`  in  1  byte ends the packet; grant is released after it.
- `req0_ready`, `req1_ready`  out  1  one-cycle accept pulse; transfer occurs when valid and ready are both high at a clk100 edge.
- `tx_sbyte`  out  8  byte to transmitter.
- `tx_send`  out  1  one-cycle start pulse to transmitter.
- `tx_busy`  in  1  transmitter busy flag.
- `grant`  out  2  one-hot current owner; 2'b00 when none.
- `timeout`  out  1  one-cycle pulse when a lock is revoked by timeout.

## Operation
- Clock and reset: single clock `clk100`; `reset_n` is synchronous, active-low. All state is updated only on `clk100` rising edges.
- States are IDLE, ACCEPT, SEND, WAIT_BUSY, WAIT_DONE and LOCKED.
- IDLE, entered on reset:
  - Arbitration happens only when `tx_busy`=0 and at least one valid is high.
  - If only one requester is valid, it wins.
  - If both are valid, the requester other than `last_served` wins.
  - The winner is set in `grant`; next state is ACCEPT.
- ACCEPT: `reqN_ready`=1 for the granted N only. At the edge, data goes to the hold register and last to `hold_last`; next state is SEND.
- SEND: `tx_send`=1 and `tx_sbyte`=hold register; next state is WAIT_BUSY.
- WAIT_BUSY: wait for `tx_busy`=1, then go to WAIT_DONE.
- WAIT_DONE: wait for `tx_busy`=0. Then:
  - if `hold_last`=1: `last_served`←owner, `grant`←0, next state IDLE;
  - otherwise next state LOCKED, with the timeout counter cleared.
- LOCKED:
  - If the owner's valid is high, go to ACCEPT. The other requester is ignored.
  - Otherwise the counter increments. When it reaches LOCK_TIMEOUT-1: `timeout` pulses, `last_served`←owner, `grant`←0, next state IDLE.
- The ready outputs and `tx_send` are combinational decodes of state and `grant`. `tx_sbyte` is registered.
- Reset values: state IDLE; `grant`=00; `tx_sbyte`=00; `tx_send`=0; both readies 0; `timeout`=0; `last_served`=1 (req0 wins the first tie); `hold_last`=0; timeout counter 0.
- Reset mid-transfer: the controller returns to IDLE immediately and drops any held byte. The transmitter is reset by its own reset and is outside this block.

## Timing
- Unlocked start: valid seen in IDLE at cycle 0 → ready at cycle 1 → `tx_send` at cycle 2 → WAIT_BUSY at cycle 3.
- `tx_serial` raises busy at cycle 3, so WAIT_DONE is entered at cycle 4.
- Byte period is 10×(RCONST+1) cycles from `tx_send`, plus 3 cycles of controller overhead before the next `tx_send`.
- Locked next byte: valid already high when WAIT_DONE exits → LOCKED 1 cycle → ACCEPT → SEND. The next `tx_send` is 3 cycles after busy falls.
- Arbitration is never taken while `tx_busy`=1. If an external source holds busy high, IDLE waits.
- If `tx_busy` never rises after SEND, the controller stays in WAIT_BUSY. This is a transmitter fault and is not handled here.
- At most one ready pulse exists per byte. A ready pulse never coincides with `tx_send`.
- The timeout counter is 20 bits. It is cleared on every entry to LOCKED and does not run in other states.

## Test plan
- Reset, then req0 sends 0x55 with last=1 → one req0_ready pulse, `tx_send` 2 cycles after valid, `tx_sbyte`=0x55, `grant` returns to 00 after busy falls.
- Both requesters valid from reset, each sending one byte with last=1 (A1, B1) → A1 is sent first, then B1. A second simultaneous round is served req0 first again, since req1 was last served.
- req0 sends a 3-byte packet 0x01,0x02,0x03(last) while req1 is valid throughout → req1_ready stays 0 until 0x03 completes, then req1 is granted.
- req0 sends 0x10 with last=0, then drops valid; LOCK_TIMEOUT=50 → `timeout` pulses exactly 50 cycles after entering LOCKED, then pending req1 is granted.
- `reset_n` is pulsed low during WAIT_DONE → on the next edge all outputs take their reset values and no ready pulse follows. A fresh request is then served normally.
- `tx_busy` is forced high while idle with req0 valid → no ready pulse until busy is released, then normal 2-cycle latency to `tx_send`.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte transmitter between two valid/ready
// producers, holding the grant for a whole packet and revoking stalled locks.
module uart_tx_arbiter #(
  parameter int LOCK_TIMEOUT = 100000
) (
  input  logic       clk100,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_sbyte,
  output logic       tx_send,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       timeout
);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    SEND,
    WAIT_BUSY,
    WAIT_DONE,
    LOCKED
  } state_e;

  localparam logic [19:0] LOCK_LAST = 20'(LOCK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_last_q, hold_last_d;
  logic        last_served_q, last_served_d;
  logic [19:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        owner_valid;

  assign owner_valid = (grant_q[0] & req0_valid) | (grant_q[1] & req1_valid);

  // NOTE: every register, the hold byte included, is reset so a reset
  // mid-transfer leaves no stale byte on tx_sbyte.
  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      hold_q        <= 8'h00;
      hold_last_q   <= 1'b0;
      last_served_q <= 1'b1;
      cnt_q         <= 20'd0;
      timeout_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q       <= state_d;
      grant_q       <= grant_d;
      hold_q        <= hold_d;
      hold_last_q   <= hold_last_d;
      last_served_q <= last_served_d;
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    // NOTE: defaults first keep this block free of inferred latches.
    state_d       = state_q;
    grant_d       = grant_q;
    hold_d        = hold_q;
    hold_last_d   = hold_last_q;
    last_served_d = last_served_q;
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!tx_busy && (req0_valid || req1_valid)) begin
          if (req0_valid && req1_valid) begin
            grant_d = last_served_q ? 2'b01 : 2'b10;
          end else begin
            grant_d = req0_valid ? 2'b01 : 2'b10;
          end
          state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        hold_d      = grant_q[0] ? req0_data : req1_data;
        hold_last_d = grant_q[0] ? req0_last : req1_last;
        state_d     = SEND;
      end
      SEND: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (hold_last_q) begin
            last_served_d = grant_q[1];
            grant_d       = 2'b00;
            state_d       = IDLE;
          end else begin
            cnt_d   = 20'd0;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        // The other requester is ignored until this packet ends or stalls out.
        if (owner_valid) begin
          state_d = ACCEPT;
        end else if (cnt_q == LOCK_LAST) begin
          timeout_d     = 1'b1;
          last_served_d = grant_q[1];
          grant_d       = 2'b00;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req0_ready = (state_q == ACCEPT) && grant_q[0];
  assign req1_ready = (state_q == ACCEPT) && grant_q[1];
  assign tx_send    = (state_q == SEND);
  assign tx_sbyte   = hold_q;
  assign grant      = grant_q;
  assign timeout    = timeout_q;

endmodule
